// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU: arbitrate, issue, register result.
// Optional ALU_ARB_ROUND_ROBIN_EN: alternate ties between requesters (default: requester 0 wins ties).
module alu_arbiter (
  input  logic        input_CLK,
  input  logic        input_Reset_n,
  input  logic        input_Req0,
  input  logic        input_Req1,
  input  logic [15:0] input_A0,
  input  logic [15:0] input_B0,
  input  logic [15:0] input_A1,
  input  logic [15:0] input_B1,
  input  logic [3:0]  input_Op0,
  input  logic [3:0]  input_Op1,
  output logic        output_Grant0,
  output logic        output_Grant1,
  output logic [15:0] output_ALU_A,
  output logic [15:0] output_ALU_B,
  output logic [3:0]  output_ALU_Op,
  input  logic [15:0] input_ALU_Result,
  input  logic        input_ALU_Zero,
  input  logic        input_ALU_Negative,
  input  logic        input_ALU_Carry,
  output logic [15:0] output_Result,
  output logic        output_Zero,
  output logic        output_Negative,
  output logic        output_Carry,
  output logic        output_Valid0,
  output logic        output_Valid1,
  output logic        output_OpError
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t      state, state_nxt;
  logic        any_req, arb_en, pick, winner, undef_op;
  logic [15:0] lat_a, lat_b;
  logic [3:0]  lat_op;

  assign any_req = input_Req0 | input_Req1;
  assign arb_en  = any_req & ((state == IDLE) | (state == DONE));

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic rr_ptr;  // requester that wins the next tie

  always_comb begin
    pick = 1'b0;
    if (input_Req0 & input_Req1) pick = rr_ptr;
    else                         pick = input_Req1;
  end

  // Point at whoever lost the latest grant, so a tie goes to the one not served last.
  always_ff @(posedge input_CLK or negedge input_Reset_n) begin
    if (!input_Reset_n)  rr_ptr <= 1'b0;
    else if (arb_en)     rr_ptr <= ~pick;
  end
`else
  assign pick = ~input_Req0;
`endif

  always_comb begin
    case (lat_op)
      4'b1001, 4'b1010, 4'b1011, 4'b1101, 4'b1110, 4'b1111: undef_op = 1'b1;
      default:                                              undef_op = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = DONE;
      DONE:    state_nxt = any_req ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge input_CLK or negedge input_Reset_n) begin
    if (!input_Reset_n) state <= IDLE;
    else                state <= state_nxt;
  end

  // Latched operands drive the ALU directly; they only change on an arbitration edge.
  assign output_ALU_A  = lat_a;
  assign output_ALU_B  = lat_b;
  assign output_ALU_Op = lat_op;

  always_ff @(posedge input_CLK or negedge input_Reset_n) begin
    if (!input_Reset_n) begin
      winner          <= 1'b0;
      lat_a           <= '0;
      lat_b           <= '0;
      lat_op          <= '0;
      output_Grant0   <= 1'b0;
      output_Grant1   <= 1'b0;
      output_Valid0   <= 1'b0;
      output_Valid1   <= 1'b0;
      output_OpError  <= 1'b0;
      output_Result   <= '0;
      output_Zero     <= 1'b0;
      output_Negative <= 1'b0;
      output_Carry    <= 1'b0;
    end else begin
      output_Grant0  <= arb_en & ~pick;
      output_Grant1  <= arb_en & pick;
      output_Valid0  <= (state == ISSUE) & ~winner;
      output_Valid1  <= (state == ISSUE) & winner;
      output_OpError <= (state == ISSUE) & undef_op;
      if (arb_en) begin
        winner <= pick;
        lat_a  <= pick ? input_A1  : input_A0;
        lat_b  <= pick ? input_B1  : input_B0;
        lat_op <= pick ? input_Op1 : input_Op0;
      end
      if (state == ISSUE) begin
        // Undefined opcodes still reach the ALU, but their result is replaced by a clean zero.
        output_Result   <= undef_op ? 16'h0000 : input_ALU_Result;
        output_Zero     <= undef_op | input_ALU_Zero;
        output_Negative <= ~undef_op & input_ALU_Negative;
        output_Carry    <= ~undef_op & input_ALU_Carry;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed vectors push expectations, a monitor checks each Valid.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [15:0] a0, b0, a1, b1;
  logic [3:0]  op0, op1;
  logic        g0, g1;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [15:0] alu_r;
  logic        alu_z, alu_n, alu_c;
  logic [15:0] res;
  logic        z, n, c, v0, v1, operr;

  typedef struct packed {
    logic        who;
    logic [15:0] r;
    logic        z, n, c, e;
  } exp_t;

  exp_t sb[$];
  int   total = 0, passed = 0, valid_cnt = 0;

  alu_arbiter dut (
    .input_CLK(clk), .input_Reset_n(rst_n),
    .input_Req0(req0), .input_Req1(req1),
    .input_A0(a0), .input_B0(b0), .input_A1(a1), .input_B1(b1),
    .input_Op0(op0), .input_Op1(op1),
    .output_Grant0(g0), .output_Grant1(g1),
    .output_ALU_A(alu_a), .output_ALU_B(alu_b), .output_ALU_Op(alu_op),
    .input_ALU_Result(alu_r), .input_ALU_Zero(alu_z),
    .input_ALU_Negative(alu_n), .input_ALU_Carry(alu_c),
    .output_Result(res), .output_Zero(z), .output_Negative(n), .output_Carry(c),
    .output_Valid0(v0), .output_Valid1(v1), .output_OpError(operr)
  );

  always #5 clk = ~clk;

  // Stand-in ALU; undefined codes return A^B so the forced zero is visible.
  always_comb begin
    logic [16:0] t;
    t = '0;
    case (alu_op)
      4'd0:    t = {1'b0, alu_a} + {1'b0, alu_b};
      4'd1:    t = {1'b0, alu_a} - {1'b0, alu_b};
      4'd2:    t = {1'b0, alu_a & alu_b};
      4'd3:    t = {1'b0, alu_a | alu_b};
      default: t = {1'b0, alu_a ^ alu_b};
    endcase
    alu_r = t[15:0];
    alu_c = t[16];
    alu_z = (t[15:0] == 16'h0000);
    alu_n = t[15];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (g0 & g1) check("grant_onehot", {g1, g0}, 2'b00);
      if (v0 & v1) check("valid_onehot", {v1, v0}, 2'b00);
      if (v0 | v1) begin
        valid_cnt++;
        if (sb.size() == 0) check("unexpected_valid", {v1, v0}, 2'b00);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("valid_owner", {v1, v0}, e.who ? 2'b10 : 2'b01);
          check("result", res, e.r);
          check("flags_znc", {z, n, c}, {e.z, e.n, e.c});
          check("op_error", operr, e.e);
        end
      end
    end
  end

  task automatic do_op(input logic id, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] op, input logic [15:0] r,
                       input logic ez, input logic en, input logic ec, input logic ee);
    sb.push_back('{who: id, r: r, z: ez, n: en, c: ec, e: ee});
    if (id) begin req1 = 1'b1; a1 = a; b1 = b; op1 = op; end
    else    begin req0 = 1'b1; a0 = a; b0 = b; op0 = op; end
    @(posedge clk); @(negedge clk);
    check("grant", {g1, g0}, id ? 2'b10 : 2'b01);
    check("issue_operands", {alu_a, alu_b, alu_op}, {a, b, op});
    if (id) req1 = 1'b0; else req0 = 1'b0;
    @(posedge clk); @(negedge clk);
    check("valid_latency", {v1, v0}, id ? 2'b10 : 2'b01);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {g0, g1, v0, v1, operr, alu_a, alu_b, alu_op, res, z, n, c}, 64'd0);
  endtask

  initial begin
    int gap, snap;
    logic ew;
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; op0 = '0; op1 = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset_outputs");
    rst_n = 1'b1;

    // id, A, B, op, result, Z, N, C, OpError
    do_op(1'b0, 16'h0005, 16'h0003, 4'b0000, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(1'b1, 16'h0000, 16'h0001, 4'b0001, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0);
    do_op(1'b0, 16'h1234, 16'h00FF, 4'b1001, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    do_op(1'b1, 16'hFFFF, 16'h0001, 4'b0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    do_op(1'b0, 16'hF0F0, 16'h0FF0, 4'b0010, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(1'b1, 16'h00FF, 16'h0F0F, 4'b1100, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(1'b0, 16'h8000, 16'h0001, 4'b1111, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    @(posedge clk); @(negedge clk);

    // Reset clears the pointer so the tie sequence starts at requester 0.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req0 = 1'b1; a0 = 16'd1;  b0 = 16'd2; op0 = 4'b0000;
    req1 = 1'b1; a1 = 16'd10; b1 = 16'd4; op1 = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      gap = 0;
      do begin
        @(posedge clk); @(negedge clk);
        gap++;
      end while (!(g0 | g1) && gap < 6);
      check("tie_gap", gap, (k == 0) ? 1 : 2);
`ifdef ALU_ARB_ROUND_ROBIN_EN
      ew = k[0];
`else
      ew = 1'b0;
`endif
      check("tie_grant", {g1, g0}, ew ? 2'b10 : 2'b01);
      if (ew) sb.push_back('{who: 1'b1, r: 16'd6, z: 1'b0, n: 1'b0, c: 1'b0, e: 1'b0});
      else    sb.push_back('{who: 1'b0, r: 16'd3, z: 1'b0, n: 1'b0, c: 1'b0, e: 1'b0});
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clk);

    // Requester 1 arrives during the DONE cycle of a requester-0 op: no IDLE gap.
    sb.push_back('{who: 1'b0, r: 16'h000F, z: 1'b0, n: 1'b0, c: 1'b0, e: 1'b0});
    req0 = 1'b1; a0 = 16'h0007; b0 = 16'h0008; op0 = 4'b0000;
    @(posedge clk); @(negedge clk);
    check("b2b_grant0", {g1, g0}, 2'b01);
    req0 = 1'b0;
    @(posedge clk); @(negedge clk);
    check("b2b_done_valid0", v0, 1'b1);
    sb.push_back('{who: 1'b1, r: 16'h0F00, z: 1'b0, n: 1'b0, c: 1'b0, e: 1'b0});
    req1 = 1'b1; a1 = 16'hFF00; b1 = 16'h0F0F; op1 = 4'b0010;
    @(posedge clk); @(negedge clk);
    check("b2b_grant1", {g1, g0}, 2'b10);
    req1 = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during ISSUE aborts the operation.
    req0 = 1'b1; a0 = 16'h1111; b0 = 16'h2222; op0 = 4'b0000;
    @(posedge clk); @(negedge clk);
    check("abort_grant", g0, 1'b1);
    rst_n = 1'b0;
    #1;
    check_all_zero("abort_outputs");
    req0 = 1'b0;
    snap = valid_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_no_valid", valid_cnt, snap);
    check("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
